// File: rtl/byte_serial_adder.sv
// Byte-serial word adder. Operand words arrive one byte pair per handshake,
// least significant byte first. Each byte goes through one 8-bit carry-lookahead
// adder, and the carry between bytes is held in a register. A single output
// register with ready/valid gives one cycle of latency and streams without gaps.
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   in_valid/in_ready            input byte handshake (in_ready is combinational)
//   in_a, in_b, cin, in_last     operand bytes, word carry-in (first byte only), last-byte flag
//   out_valid/out_ready          output byte handshake
//   out_sum, out_last            sum byte and the flag marking the end of its word
//   out_cout, out_ovf            word carry-out and signed overflow (only when out_last=1)
//   len_err                      combinational pulse when a word is cut off at NBYTES

// 8-bit carry-lookahead adder.
// Ports: a, b operands; c0 carry-in; sum result; c_1 carry-out.
module carry_lookahead (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       c0,
    output logic [7:0] sum,
    output logic       c_1
);
    logic [7:0] g;
    logic [7:0] p;
    logic [8:0] c;

    // Each carry is built straight from the generate/propagate terms,
    // not rippled from the carry below it.
    always_comb begin
        g = a & b;
        p = a ^ b;
        c = '0;
        c[0] = c0;
        for (int i = 0; i < 8; i++) begin
            logic ci;
            logic prop;
            ci   = 1'b0;
            prop = 1'b1;
            for (int j = i; j >= 0; j--) begin
                ci   = ci | (prop & g[j]);
                prop = prop & p[j];
            end
            c[i+1] = ci | (prop & c0);
        end
    end

    assign sum = p ^ c[7:0];
    assign c_1 = c[8];
endmodule

module byte_serial_adder #(
    parameter int unsigned NBYTES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_a,
    input  logic [7:0] in_b,
    input  logic       cin,
    input  logic       in_last,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_sum,
    output logic       out_last,
    output logic       out_cout,
    output logic       out_ovf,
    output logic       len_err
);
    localparam int unsigned CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic          carry_q, carry_d;
    logic          out_valid_q, out_valid_d;
    logic [7:0]    out_sum_q, out_sum_d;
    logic          out_last_q, out_last_d;
    logic          out_cout_q, out_cout_d;
    logic          out_ovf_q, out_ovf_d;

    logic          accept;
    logic          at_limit;
    logic          word_end;
    logic          c0;
    logic [7:0]    sum;
    logic          c_1;

    // The output register can take a new byte when empty or being drained.
    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign at_limit = (count_q == CW'(NBYTES - 1));
    assign word_end = in_last || at_limit;
    assign c0       = (state_q == IDLE) ? cin : carry_q;
    assign len_err  = accept && at_limit && !in_last;

    carry_lookahead u_cla (
        .a   (in_a),
        .b   (in_b),
        .c0  (c0),
        .sum (sum),
        .c_1 (c_1)
    );

    // Next-state and output-stage logic.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        carry_d     = carry_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_last_d  = out_last_q;
        out_cout_d  = out_cout_q;
        out_ovf_d   = out_ovf_q;

        if (accept) begin
            carry_d     = c_1;
            out_valid_d = 1'b1;
            out_sum_d   = sum;
            out_last_d  = word_end;
            out_cout_d  = word_end && c_1;
            out_ovf_d   = word_end && (in_a[7] ~^ in_b[7]) && (in_a[7] ^ sum[7]);
            if (word_end) begin
                state_d = IDLE;
                count_d = '0;
            end else begin
                state_d = BUSY;
                count_d = count_q + CW'(1);
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            count_q     <= '0;
            carry_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_last_q  <= 1'b0;
            out_cout_q  <= 1'b0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            carry_q     <= carry_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_last_q  <= out_last_d;
            out_cout_q  <= out_cout_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_last  = out_last_q;
    assign out_cout  = out_cout_q;
    assign out_ovf   = out_ovf_q;
endmodule

// File: tb/tb_byte_serial_adder.sv
// Testbench for byte_serial_adder. Words are added as whole integers in a
// reference model, and the model splits each result into the per-byte outputs
// the adder should produce.
module tb_byte_serial_adder;
    localparam int unsigned NBYTES = 4;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic       cin;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_sum;
    logic       out_last;
    logic       out_cout;
    logic       out_ovf;
    logic       len_err;

    byte_serial_adder #(.NBYTES(NBYTES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .cin       (cin),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_last  (out_last),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .len_err   (len_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One input byte together with the output the model expects for it.
    typedef struct {
        bit [7:0] a;
        bit [7:0] b;
        bit       c;
        bit       last;
        bit [7:0] s;
        bit       l;
        bit       co;
        bit       ov;
        bit       le;
    } stim_t;

    stim_t stim_q[$];
    stim_t cur;
    bit    ov_exp;
    bit    rand_rdy;
    bit    rand_gap;
    bit    stall_arm;
    int    stall_left;
    int    n_checks;
    int    n_fail;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Add the two words with plain integer arithmetic, then queue one input
    // byte per operand byte. If trunc is set, in_last is never raised and the
    // adder is expected to close the word at NBYTES on its own.
    task automatic push_word(input int len, input logic [127:0] a_in, input logic [127:0] b_in,
                             input bit c, input bit trunc);
        logic [127:0] mask;
        logic [127:0] a;
        logic [127:0] b;
        logic [128:0] tot;
        stim_t        it;
        mask = (len >= 16) ? '1 : ((128'(1) << (8 * len)) - 128'(1));
        a    = a_in & mask;
        b    = b_in & mask;
        tot  = 129'(a) + 129'(b) + 129'(c);
        for (int i = 0; i < len; i++) begin
            it.a    = a[8*i +: 8];
            it.b    = b[8*i +: 8];
            it.c    = (i == 0) ? c : 1'($urandom);
            it.l    = (i == len - 1);
            it.last = it.l && !trunc;
            it.s    = tot[8*i +: 8];
            it.co   = it.l && tot[8*len];
            it.ov   = it.l && (a[8*len-1] == b[8*len-1]) && (tot[8*len-1] != a[8*len-1]);
            it.le   = it.l && trunc;
            stim_q.push_back(it);
        end
    endtask

    // One clock cycle: drive the inputs, check the outputs, then advance the model.
    task automatic step();
        stim_t it;
        bit    drive;
        bit    acc;
        @(negedge clk);
        if (stall_arm && ov_exp) begin
            stall_left = 3;
            stall_arm  = 1'b0;
        end
        if (stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
        end else if (rand_rdy) begin
            out_ready = ($urandom_range(0, 3) != 0);
        end else begin
            out_ready = 1'b1;
        end
        drive    = (stim_q.size() > 0) && (!rand_gap || $urandom_range(0, 4) != 0);
        in_valid = drive;
        if (drive) begin
            it      = stim_q[0];
            in_a    = it.a;
            in_b    = it.b;
            cin     = it.c;
            in_last = it.last;
        end else begin
            in_a    = 8'($urandom);
            in_b    = 8'($urandom);
            cin     = 1'($urandom);
            in_last = 1'($urandom);
        end
        #1;
        check_eq("in_ready", 32'(in_ready), 32'(!ov_exp || out_ready));
        check_eq("out_valid", 32'(out_valid), 32'(ov_exp));
        if (ov_exp) begin
            check_eq("out_sum", 32'(out_sum), 32'(cur.s));
            check_eq("out_last", 32'(out_last), 32'(cur.l));
            check_eq("out_cout", 32'(out_cout), 32'(cur.co));
            check_eq("out_ovf", 32'(out_ovf), 32'(cur.ov));
        end
        acc = drive && (!ov_exp || out_ready);
        check_eq("len_err", 32'(len_err), 32'(acc && it.le));
        @(posedge clk);
        if (acc) begin
            cur    = it;
            ov_exp = 1'b1;
            void'(stim_q.pop_front());
        end else if (out_ready) begin
            ov_exp = 1'b0;
        end
    endtask

    // Run until every queued byte has been accepted and drained, within a cycle budget.
    task automatic run(input int budget);
        int n;
        n = 0;
        while ((stim_q.size() > 0 || ov_exp) && n < budget) begin
            step();
            n++;
        end
        check_eq("drain_timeout", 32'(stim_q.size() > 0 || ov_exp), 32'(0));
        stim_q.delete();
    endtask

    task automatic check_cleared(input string tag);
        check_eq({tag, "_out_valid"}, 32'(out_valid), 32'(0));
        check_eq({tag, "_out_sum"}, 32'(out_sum), 32'(0));
        check_eq({tag, "_out_last"}, 32'(out_last), 32'(0));
        check_eq({tag, "_out_cout"}, 32'(out_cout), 32'(0));
        check_eq({tag, "_out_ovf"}, 32'(out_ovf), 32'(0));
        check_eq({tag, "_len_err"}, 32'(len_err), 32'(0));
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        ov_exp     = 1'b0;
        cur        = '{default: '0};
        rand_rdy   = 1'b0;
        rand_gap   = 1'b0;
        stall_arm  = 1'b0;
        stall_left = 0;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_a       = '0;
        in_b       = '0;
        cin        = 1'b0;
        in_last    = 1'b0;
        out_ready  = 1'b1;

        // Reset state.
        repeat (2) @(negedge clk);
        check_cleared("reset");
        rst_n = 1'b1;

        // 4-byte word with carries rippling through the low two bytes.
        push_word(4, 128'h12345678, 128'h0000FFFF, 1'b0, 1'b0);
        run(50);

        // Carry-in through an all-ones word, then a 1-byte signed overflow.
        push_word(2, 128'hFFFF, 128'h0000, 1'b1, 1'b0);
        push_word(1, 128'h7F, 128'h01, 1'b0, 1'b0);
        run(50);

        // Downstream stall for 3 cycles after the first sum byte.
        stall_arm = 1'b1;
        push_word(4, 128'h00FFFFFF, 128'h00000001, 1'b0, 1'b0);
        push_word(3, 128'h80FF01, 128'h80FF01, 1'b1, 1'b0);
        run(50);

        // Five bytes with in_last only on the fifth: the word is cut at NBYTES
        // and the fifth byte starts a new word with its own carry-in.
        push_word(4, 128'hFFFFFFFF, 128'h00000001, 1'b0, 1'b1);
        push_word(1, 128'h10, 128'h20, 1'b0, 1'b0);
        run(50);

        // Reset after two bytes of a word that leaves carry set.
        push_word(4, 128'hFFFFFFFF, 128'h00000001, 1'b0, 1'b0);
        step();
        step();
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_cleared("midword_reset");
        stim_q.delete();
        ov_exp = 1'b0;
        cur    = '{default: '0};
        @(negedge clk);
        rst_n = 1'b1;
        push_word(1, 128'h01, 128'h01, 1'b0, 1'b0);
        run(50);

        // Random word lengths, operands, gaps and backpressure.
        rand_rdy = 1'b1;
        rand_gap = 1'b1;
        for (int w = 0; w < 300; w++) begin
            int           len;
            bit           trunc;
            logic [127:0] a;
            logic [127:0] b;
            len   = int'($urandom_range(1, NBYTES));
            trunc = (len == NBYTES) && ($urandom_range(0, 3) == 0);
            for (int k = 0; k < 4; k++) begin
                a[32*k +: 32] = $urandom;
                b[32*k +: 32] = $urandom;
            end
            push_word(len, a, b, 1'($urandom), trunc);
        end
        run(20000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
